// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Sequencing controller for a bit-serial adder. Two WIDTH-bit operands and
// a carry-in are captured on a start/ready handshake, then added LSB-first
// through one full-adder cell and a carry flip-flop, one bit per clock. The
// WIDTH-bit sum and the carry-out are registered and held until the next
// completion or reset.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (priority over start)
//   start  request, accepted only while ready=1
//   a, b   operands (WIDTH bits), sampled on accept only
//   cin    carry-in, sampled on accept only
//   ready  high in IDLE and DONE
//   busy   high in SHIFT
//   done   one-cycle pulse, high in DONE
//   sum    registered result (WIDTH bits)
//   carry  registered carry-out
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Partial-sum register holds the WIDTH-1 bits already produced; the last
  // bit goes straight from the adder cell into sum on the final step.
  logic [WIDTH-2:0] s_sr;
  logic [WIDTH-2:0] s_shift;
  logic             c_ff;
  logic [CW-1:0]    cnt;

  // Single full-adder cell fed by the operand LSBs and the carry flip-flop.
  logic s_bit;
  logic co_bit;
  assign s_bit  = a_sr[0] ^ b_sr[0] ^ c_ff;
  assign co_bit = (a_sr[0] & b_sr[0]) | (a_sr[0] & c_ff) | (b_sr[0] & c_ff);

  // New sum bit enters at the top; older bits move toward the LSB.
  generate
    if (WIDTH == 2) begin : g_narrow
      assign s_shift = s_bit;
    end else begin : g_wide
      assign s_shift = {s_bit, s_sr[WIDTH-2:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      c_ff  <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE accepts exactly like IDLE so back-to-back operation is possible.
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            c_ff  <= cin;
            s_sr  <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          c_ff <= co_bit;
          s_sr <= s_shift;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= {s_bit, s_sr};
            carry <= co_bit;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs are decoded straight from the state register.
  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencing controller for a bit-serial adder. It accepts two WIDTH-bit operands and a carry-in through a start/ready handshake, then loads them into internal shift registers. It adds them LSB-first through a single full-adder cell with a carry flip-flop, one bit per clock, and presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It is the sequencing front end for the team's serial arithmetic datapath, replacing parallel `a+b` with one full-adder bit per cycle.

## Interface
- WIDTH, 4, operand/sum width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- a  input  WIDTH  operand A, sampled on accept only
- b  input  WIDTH  operand B, sampled on accept only
- cin  input  1  carry-in, sampled on accept only
- ready  output  1  high in IDLE and DONE (start will be accepted)
- busy  output  1  high in SHIFT
- done  output  1  one-cycle pulse, high in DONE
- sum  output  WIDTH  registered result, held until next completion or reset
- carry  output  1  registered carry-out, held like sum

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Internal state: a_sr, b_sr, s_sr (WIDTH each), c_ff (1), cnt (clog2(WIDTH) bits).
- IDLE
  - start=1: a_sr←a, b_sr←b, c_ff←cin, s_sr←0, cnt←0, go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT, each cycle:
  - s = a_sr[0]^b_sr[0]^c_ff
  - co = majority(a_sr[0], b_sr[0], c_ff)
  - s_sr←{s, s_sr[WIDTH-1:1]}
  - a_sr←a_sr>>1, b_sr←b_sr>>1, c_ff←co, cnt←cnt+1
- SHIFT exit: on the step where cnt==WIDTH-1:
  - sum←{s, s_sr[WIDTH-1:1]}, carry←co
  - go to DONE
- DONE: done=1 for exactly this cycle.
  - start=1: accept exactly as in IDLE (back-to-back), go to SHIFT.
  - Otherwise go to IDLE.
- start while busy=1 is ignored: no queuing, and operands are not re-sampled.
- a, b and cin may change freely after acceptance without affecting the operation in flight.
- Arithmetic: {carry,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow condition beyond carry.
- Reset, including mid-operation: next state IDLE. sum=0, carry=0, done=0, busy=0, ready=1, internal registers cleared. The in-flight operation is discarded and produces no done pulse.
- rst has priority over start in the same cycle.

## Timing
- Accept edge = rising edge E where start=1 and ready=1.
- busy is high for exactly WIDTH cycles after E.
- sum, carry and done update at edge E+WIDTH. done is high from E+WIDTH to E+WIDTH+1.
- Latency from accept to result is WIDTH cycles.
- Maximum throughput is one operation per WIDTH+1 cycles, using back-to-back start in DONE.
- All outputs are registered or decoded directly from the state register. No combinational path exists from inputs to outputs.
- ready = (state==IDLE)|(state==DONE). busy = (state==SHIFT).

## Test plan
- Reset: hold rst 3 cycles with start=1 and random a/b. Required: sum=0, carry=0, done=0, busy=0, ready=1 throughout, and no accept.
- Basic add, WIDTH=4: a=0011, b=0101, cin=0, start pulsed 1 cycle. Required: busy high 4 cycles, then done 1 cycle with sum=1000, carry=0. Values held after done.
- Carry chain:
  - a=1111, b=0001, cin=0 → sum=0000, carry=1.
  - a=1111, b=1111, cin=1 → sum=1111, carry=1.
- Start during busy: accept a=0001, b=0001, then hold start=1 with a=1110, b=1110 during SHIFT. Required: first done shows sum=0010, carry=0. Because start is still high in DONE, the second operation is accepted there, and the next done arrives 5 cycles later with sum=1100, carry=1.
- Reset mid-operation: accept a=0110, b=0011, then assert rst at the 2nd SHIFT cycle. Required: next cycle all outputs are at reset values and no done pulse occurs. A fresh accept then completes correctly.
- Random regression, WIDTH=4 and WIDTH=8: 500 operations with random start gaps (including back-to-back). Compare {carry,sum} against a+b+cin and check done spacing ≥ WIDTH+1.
